// File: rtl/memory_stage_if.sv
// Memory-side bus of the memory stage: request/address/data out, ack/read-data back.
interface memory_stage_if;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemWe;
  logic        MemPWe;
  logic        MemAck;
  logic [31:0] MemRData;

  modport master (
    output MemReq, MemAddr, MemWData, MemWe, MemPWe,
    input  MemAck, MemRData
  );

  modport slave (
    input  MemReq, MemAddr, MemWData, MemWe, MemPWe,
    output MemAck, MemRData
  );
endinterface

// File: rtl/memory_stage.sv
// Memory stage: captures execute-stage results, runs data/pixel memory accesses with a stall
// handshake and drives a registered IO port. Define MEM_TIMEOUT_EN for a 16-cycle access timeout.
module memory_stage (
  input  logic           clk,
  input  logic           rst,
  input  logic           RegWrite,
  input  logic           MemWrite,
  input  logic           MemPWrite,
  input  logic           IOFlag,
  input  logic [1:0]     MemToReg,
  input  logic [31:0]    ALUResult,
  input  logic [31:0]    WriteData,
  input  logic [3:0]     Rd,
  output logic           Stall,
  memory_stage_if.master mem_io,
  input  logic [31:0]    IOIn,
  output logic [31:0]    IOOut,
  output logic           RegWriteOut,
  output logic [1:0]     MemToRegOut,
  output logic [31:0]    ReadDataOut,
  output logic [31:0]    ALUResultOut,
  output logic [3:0]     RdOut,
  output logic           Fault
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_pwrite;
    logic        io_flag;
    logic [1:0]  mem_to_reg;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [3:0]  rd;
  } op_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [3:0]  rd;
  } wb_t;

  state_e      state_q, state_d;
  op_t         op_q, op_d, op_in;
  wb_t         wb_q, wb_d, wb_pass;
  logic [31:0] io_out_q, io_out_d;
  logic        in_is_mem;
  logic        capture;
  logic        timeout;

  assign op_in = '{reg_write: RegWrite, mem_write: MemWrite, mem_pwrite: MemPWrite,
                   io_flag: IOFlag, mem_to_reg: MemToReg, alu_result: ALUResult,
                   write_data: WriteData, rd: Rd};

  assign in_is_mem = !IOFlag && (MemWrite || MemPWrite || (MemToReg == 2'b10));

  assign wb_pass = '{reg_write: op_q.reg_write, mem_to_reg: op_q.mem_to_reg, read_data: '0,
                     alu_result: op_q.alu_result, rd: op_q.rd};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wb_d     = '0;
    io_out_d = io_out_q;
    capture  = 1'b0;
    case (state_q)
      StIdle: begin
        // Anything held here is a single-cycle op (or the cleared bubble).
        wb_d = wb_pass;
        if (op_q.io_flag && (op_q.mem_to_reg == 2'b11)) wb_d.read_data = IOIn;
        if (op_q.io_flag && op_q.mem_write) io_out_d = op_q.write_data;
        capture = 1'b1;
      end
      StAccess: begin
        if (mem_io.MemAck) begin
          wb_d = wb_pass;
          if (op_q.mem_to_reg == 2'b10) wb_d.read_data = mem_io.MemRData;
          capture = 1'b1;
        end else if (timeout) begin
          // Abandon the access so the idle path does not retire it as an ALU op.
          state_d = StIdle;
          op_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (capture) begin
      op_d    = op_in;
      state_d = in_is_mem ? StAccess : StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      wb_q     <= '0;
      io_out_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wb_q     <= wb_d;
      io_out_q <= io_out_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [3:0] tmo_cnt_q, tmo_cnt_d;
  logic       fault_q, fault_d;

  assign timeout = (state_q == StAccess) && !mem_io.MemAck && (tmo_cnt_q == 4'd15);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    fault_d   = fault_q || timeout;
    if (capture && in_is_mem) begin
      tmo_cnt_d = 4'd0;
    end else if ((state_q == StAccess) && !mem_io.MemAck) begin
      tmo_cnt_d = tmo_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= 4'd0;
      fault_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      fault_q   <= fault_d;
    end
  end

  assign Fault = fault_q;
`else
  assign timeout = 1'b0;
  assign Fault   = 1'b0;
`endif

  assign Stall           = (state_q == StAccess) && !mem_io.MemAck;
  assign mem_io.MemReq   = (state_q == StAccess);
  assign mem_io.MemAddr  = mem_io.MemReq ? op_q.alu_result : 32'd0;
  assign mem_io.MemWData = mem_io.MemReq ? op_q.write_data : 32'd0;
  assign mem_io.MemPWe   = mem_io.MemReq && op_q.mem_pwrite;
  assign mem_io.MemWe    = mem_io.MemReq && op_q.mem_write && !op_q.mem_pwrite;

  assign IOOut        = io_out_q;
  assign RegWriteOut  = wb_q.reg_write;
  assign MemToRegOut  = wb_q.mem_to_reg;
  assign ReadDataOut  = wb_q.read_data;
  assign ALUResultOut = wb_q.alu_result;
  assign RdOut        = wb_q.rd;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table, directed multi-cycle sequences and a
// randomized run against an op-level reference model. Honours MEM_TIMEOUT_EN if defined.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite, MemWrite, MemPWrite, IOFlag;
  logic [1:0]  MemToReg;
  logic [31:0] ALUResult, WriteData, IOIn;
  logic [3:0]  Rd;
  logic        Stall, RegWriteOut, Fault;
  logic [31:0] IOOut, ReadDataOut, ALUResultOut;
  logic [1:0]  MemToRegOut;
  logic [3:0]  RdOut;

  int checks = 0;
  int errors = 0;

  memory_stage_if mem_if ();

  memory_stage dut (
    .clk          (clk),
    .rst          (rst),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .MemPWrite    (MemPWrite),
    .IOFlag       (IOFlag),
    .MemToReg     (MemToReg),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .Rd           (Rd),
    .Stall        (Stall),
    .mem_io       (mem_if),
    .IOIn         (IOIn),
    .IOOut        (IOOut),
    .RegWriteOut  (RegWriteOut),
    .MemToRegOut  (MemToRegOut),
    .ReadDataOut  (ReadDataOut),
    .ALUResultOut (ALUResultOut),
    .RdOut        (RdOut),
    .Fault        (Fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rw, mw, mpw, io;
    logic [1:0]  m2r;
    logic [31:0] alu, wd, ioin;
    logic [3:0]  rd;
    logic        e_rw;
    logic [1:0]  e_m2r;
    logic [31:0] e_rdata, e_alu;
    logic [3:0]  e_rd;
    logic [31:0] e_io;
  } vec_t;

  typedef struct {
    logic        rw, mw, mpw, io;
    logic [1:0]  m2r;
    logic [31:0] alu, wd;
    logic [3:0]  rd;
  } op_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rw, input logic mw, input logic mpw, input logic io,
                        input logic [1:0] m2r, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [3:0] rd);
    RegWrite = rw; MemWrite = mw; MemPWrite = mpw; IOFlag = io;
    MemToReg = m2r; ALUResult = alu; WriteData = wd; Rd = rd;
  endtask

  task automatic nop();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic chk_wb(input string tag, input logic rw, input logic [1:0] m2r,
                        input logic [31:0] rdata, input logic [31:0] alu, input logic [3:0] rd);
    chk({tag, ".RegWriteOut"}, 32'(RegWriteOut), 32'(rw));
    chk({tag, ".MemToRegOut"}, 32'(MemToRegOut), 32'(m2r));
    chk({tag, ".ReadDataOut"}, ReadDataOut, rdata);
    chk({tag, ".ALUResultOut"}, ALUResultOut, alu);
    chk({tag, ".RdOut"}, 32'(RdOut), 32'(rd));
  endtask

  function automatic logic is_mem(input op_t o);
    return !o.io && (o.mw || o.mpw || (o.m2r == 2'b10));
  endfunction

  vec_t vecs[5];

  initial begin
    op_t         pend, nxt;
    logic        pend_mem, stall_exp;
    int          wait_left, nxt_wait;
    logic [31:0] e_io, e_rdata;
    logic        e_rw;
    logic [1:0]  e_m2r;
    logic [31:0] e_alu;
    logic [3:0]  e_rd;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h15, 32'h0, 32'h0, 4'hA,
                1'b1, 2'b00, 32'h0, 32'h15, 4'hA, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'h100, 32'h0F, 32'h0, 4'h0,
                1'b0, 2'b00, 32'h0, 32'h100, 4'h0, 32'h0F};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 32'h104, 32'h0, 32'h77, 4'h3,
                1'b1, 2'b11, 32'h77, 32'h104, 4'h3, 32'h0F};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h9, 32'h1234, 4'hF,
                1'b1, 2'b01, 32'h0, 32'hFFFF_FFFF, 4'hF, 32'h0F};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 32'h108, 32'hA5A5, 32'h0, 4'h7,
                1'b1, 2'b00, 32'h0, 32'h108, 4'h7, 32'hA5A5};

    // Reset
    rst = 1'b1;
    nop();
    IOIn = 32'd0;
    mem_if.MemAck = 1'b0;
    mem_if.MemRData = 32'd0;
    tick();
    tick();
    chk_wb("reset", 1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
    chk("reset.IOOut", IOOut, 32'd0);
    chk("reset.Fault", 32'(Fault), 32'd0);
    chk("reset.Stall", 32'(Stall), 32'd0);
    chk("reset.MemReq", 32'(mem_if.MemReq), 32'd0);
    rst = 1'b0;

    // Single-cycle ops from the table: capture edge, then writeback edge
    for (int i = 0; i < 5; i++) begin
      set_op(vecs[i].rw, vecs[i].mw, vecs[i].mpw, vecs[i].io, vecs[i].m2r, vecs[i].alu,
             vecs[i].wd, vecs[i].rd);
      IOIn = vecs[i].ioin;
      tick();
      chk($sformatf("vec%0d.Stall", i), 32'(Stall), 32'd0);
      chk($sformatf("vec%0d.MemReq", i), 32'(mem_if.MemReq), 32'd0);
      nop();
      tick();
      chk_wb($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].e_m2r, vecs[i].e_rdata,
             vecs[i].e_alu, vecs[i].e_rd);
      chk($sformatf("vec%0d.IOOut", i), IOOut, vecs[i].e_io);
    end

    // Load acknowledged after three stall cycles
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h40, 32'h0, 4'h5);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("load.stall%0d", i), 32'(Stall), 32'd1);
      chk($sformatf("load.req%0d", i), 32'(mem_if.MemReq), 32'd1);
      chk($sformatf("load.addr%0d", i), mem_if.MemAddr, 32'h40);
      chk($sformatf("load.we%0d", i), 32'({mem_if.MemWe, mem_if.MemPWe}), 32'd0);
      tick();
      chk_wb($sformatf("load.bubble%0d", i), 1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
    end
    mem_if.MemAck = 1'b1;
    mem_if.MemRData = 32'hDEAD_BEEF;
    #1;
    chk("load.ackStall", 32'(Stall), 32'd0);
    nop();
    tick();
    mem_if.MemAck = 1'b0;
    chk_wb("load.wb", 1'b1, 2'b10, 32'hDEAD_BEEF, 32'h40, 4'h5);
    chk("load.reqAfter", 32'(mem_if.MemReq), 32'd0);

    // Store to both memories: pixel write only, immediate ack
    set_op(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h80, 32'h55, 4'h0);
    tick();
    mem_if.MemAck = 1'b1;
    mem_if.MemRData = 32'h1234_5678;
    #1;
    chk("pstore.req", 32'(mem_if.MemReq), 32'd1);
    chk("pstore.pwe", 32'(mem_if.MemPWe), 32'd1);
    chk("pstore.we", 32'(mem_if.MemWe), 32'd0);
    chk("pstore.wdata", mem_if.MemWData, 32'h55);
    chk("pstore.stall", 32'(Stall), 32'd0);
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h84, 32'h66, 4'h0);
    tick();
    chk_wb("pstore.wb", 1'b0, 2'b00, 32'd0, 32'h80, 4'h0);
    chk("dstore.we", 32'(mem_if.MemWe), 32'd1);
    chk("dstore.pwe", 32'(mem_if.MemPWe), 32'd0);
    chk("dstore.addr", mem_if.MemAddr, 32'h84);
    nop();
    tick();
    mem_if.MemAck = 1'b0;
    #1;
    chk("dstore.reqAfter", 32'(mem_if.MemReq), 32'd0);

    // Reset in the middle of an access, then a late ack
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h200, 32'h0, 4'h9);
    tick();
    chk("rstacc.req", 32'(mem_if.MemReq), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstacc.req0", 32'(mem_if.MemReq), 32'd0);
    chk("rstacc.stall0", 32'(Stall), 32'd0);
    chk("rstacc.IOOut", IOOut, 32'd0);
    chk_wb("rstacc", 1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
    rst = 1'b0;
    nop();
    mem_if.MemAck = 1'b1;
    mem_if.MemRData = 32'hCAFE_F00D;
    #1;
    chk("lateack.stall", 32'(Stall), 32'd0);
    tick();
    mem_if.MemAck = 1'b0;
    chk_wb("lateack", 1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
    chk("lateack.req", 32'(mem_if.MemReq), 32'd0);

    // Randomized run against the op-level model
    pend = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 4'd0};
    pend_mem = 1'b0;
    wait_left = 0;
    e_io = 32'd0;
    nxt = pend;
    nxt_wait = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      stall_exp = pend_mem && (wait_left > 0);
      if (!stall_exp) begin
        nxt.rw  = 1'($urandom);
        nxt.mw  = 1'($urandom);
        nxt.mpw = ($urandom_range(0, 3) == 0);
        nxt.io  = ($urandom_range(0, 3) == 0);
        nxt.m2r = 2'($urandom);
        nxt.alu = $urandom;
        nxt.wd  = $urandom;
        nxt.rd  = 4'($urandom);
        nxt_wait = $urandom_range(0, 4);
        set_op(nxt.rw, nxt.mw, nxt.mpw, nxt.io, nxt.m2r, nxt.alu, nxt.wd, nxt.rd);
      end
      mem_if.MemAck = pend_mem && (wait_left == 0);
      mem_if.MemRData = $urandom;
      IOIn = $urandom;
      #1;
      chk("rnd.Stall", 32'(Stall), 32'(stall_exp));
      chk("rnd.MemReq", 32'(mem_if.MemReq), 32'(pend_mem));
      if (pend_mem) begin
        chk("rnd.MemAddr", mem_if.MemAddr, pend.alu);
        chk("rnd.MemWData", mem_if.MemWData, pend.wd);
        chk("rnd.MemPWe", 32'(mem_if.MemPWe), 32'(pend.mpw));
        chk("rnd.MemWe", 32'(mem_if.MemWe), 32'(pend.mw && !pend.mpw));
      end
      if (stall_exp) begin
        {e_rw, e_m2r, e_rdata, e_alu, e_rd} = '0;
        wait_left--;
      end else begin
        e_rw = pend.rw;
        e_m2r = pend.m2r;
        e_alu = pend.alu;
        e_rd = pend.rd;
        if (pend_mem) e_rdata = (pend.m2r == 2'b10) ? mem_if.MemRData : 32'd0;
        else e_rdata = (pend.io && (pend.m2r == 2'b11)) ? IOIn : 32'd0;
        if (!pend_mem && pend.io && pend.mw) e_io = pend.wd;
        pend = nxt;
        pend_mem = is_mem(nxt);
        wait_left = nxt_wait;
      end
      tick();
      chk_wb("rnd", e_rw, e_m2r, e_rdata, e_alu, e_rd);
      chk("rnd.IOOut", IOOut, e_io);
    end

    // Access with no ack ever
    rst = 1'b1;
    nop();
    mem_if.MemAck = 1'b0;
    tick();
    rst = 1'b0;
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 32'h300, 32'h0, 4'h2);
    tick();
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tmo.stall%0d", i), 32'(Stall), 32'd1);
      chk($sformatf("tmo.fault%0d", i), 32'(Fault), 32'd0);
      tick();
    end
    chk("tmo.stallEnd", 32'(Stall), 32'd0);
    chk("tmo.reqEnd", 32'(mem_if.MemReq), 32'd0);
    chk("tmo.fault", 32'(Fault), 32'd1);
    chk_wb("tmo", 1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
    nop();
    tick();
    tick();
    chk("tmo.faultHeld", 32'(Fault), 32'd1);
    chk_wb("tmo.after", 1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
`else
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("wait.stall%0d", i), 32'(Stall), 32'd1);
      chk($sformatf("wait.req%0d", i), 32'(mem_if.MemReq), 32'd1);
      chk($sformatf("wait.fault%0d", i), 32'(Fault), 32'd0);
      tick();
    end
`endif
    rst = 1'b1;
    nop();
    tick();
    rst = 1'b0;
    chk("final.fault", 32'(Fault), 32'd0);
    chk("final.stall", 32'(Stall), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
